// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with a one-entry output register feeding the shared 4:1 Mux; 1-cycle latency, all req_ready low while the output is stalled.
// Optional burst lock (req_last port, locked flag) is enabled by defining MUX_RR_ARB_LOCK_EN.
module mux_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_valid,
  input  logic [W-1:0]  req_data [N],
  output logic [N-1:0]  req_ready,
`ifdef MUX_RR_ARB_LOCK_EN
  input  logic [N-1:0]  req_last,
`endif
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  grant
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e        state_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;
  logic [SW-1:0] sel_q;
  logic [W-1:0]  data_q;
  logic [N-1:0]  grant_q;
  logic [SW-1:0] win;
  logic          found;
  logic          can_accept;
  logic          xfer;
`ifdef MUX_RR_ARB_LOCK_EN
  logic          locked_q;
`endif

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
`ifdef MUX_RR_ARB_LOCK_EN
    // Mid-burst only the owner (still held in sel_q) may win.
    if (locked_q) begin
      found = req_valid[sel_q];
      win   = sel_q;
    end
`endif
  end

  assign can_accept = (state_q == EMPTY) || out_ready;
  assign xfer       = found && can_accept && !rst;
  assign ptr_d      = (int'(win) == N - 1) ? '0 : SW'(int'(win) + 1);

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
`ifdef MUX_RR_ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else if (xfer) begin
      state_q <= FULL;
      data_q  <= req_data[win];
      sel_q   <= win;
      grant_q <= req_ready;
`ifdef MUX_RR_ARB_LOCK_EN
      if (req_last[win]) begin
        locked_q <= 1'b0;
        ptr_q    <= ptr_d;
      end else begin
        locked_q <= 1'b1;
      end
`else
      ptr_q   <= ptr_d;
`endif
    end else if (state_q == FULL && out_ready) begin
      state_q <= EMPTY;
      grant_q <= '0;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign grant     = grant_q;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 byte multiplexer's output among N requesters with a valid/ready handshake on every input and on the output. Each cycle it chooses one requester fairly, drives the multiplexer `sel`, and captures the selected word into a one-entry output register. It sits between the producer lanes and the shared downstream consumer, and is the sequencing layer around the existing `Mux` datapath.

## Interface

- `N`, default 4: number of requesters; must be at least 2.
- `W`, default 8: data width in bits.
- `SW`, default `$clog2(N)`: select width; derived, do not override.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset (one clock, synchronous reset; polarity and synchronicity are fixed)
- `req_valid`  in  N  per-requester valid
- `req_data`  in  N×W  unpacked array `[N]` of `W`-bit words
- `req_ready`  out  N  per-requester ready; one-hot or zero
- `req_last`  in  N  end-of-burst marker; present only with `MUX_RR_ARB_LOCK_EN`
- `out_valid`  out  1  output register holds a word
- `out_data`  out  W  registered selected word
- `out_ready`  in  1  consumer accepts
- `sel`  out  SW  index of the requester whose word is in `out_data`; feeds `Mux.sel`
- `grant`  out  N  registered one-hot copy of `sel`, qualified by `out_valid`

## Operation

- `can_accept` = `!out_valid || out_ready`.
- Priority pointer `ptr` (SW bits). The winner is the first `i` with `req_valid[i]`, scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
- `req_ready[winner]` = `can_accept`; all other `req_ready` bits are 0. `req_ready` is combinational from `req_valid`, `ptr`, `out_valid` and `out_ready`, and is 0 while `rst` is high.
- Transfer on requester `i`, when `req_valid[i] && req_ready[i]`:
  - `out_data <= req_data[i]`, `out_valid <= 1`, `sel <= i`, `grant <= 1<<i`.
  - `ptr <= (i+1) mod N`, wrapping from N-1 to 0.
- Drain without refill, when `out_valid && out_ready` and no requester is valid: `out_valid <= 0`, `grant <= 0`. `sel` and `out_data` hold their values.
- Stall, when `out_valid && !out_ready`:
  - `out_data`, `sel` and `grant` are stable.
  - All `req_ready` bits are 0.
- A requester may drop `req_valid` without a handshake. Arbitration is re-evaluated every cycle.
- States:
  - EMPTY (`out_valid=0`): a request moves to FULL.
  - FULL (`out_valid=1`): `out_ready` with a request stays in FULL with a new word; `out_ready` without a request returns to EMPTY; no `out_ready` stays in FULL.

## Timing

- Latency: requester handshake to `out_valid` is 1 cycle.
- Throughput: 1 word per cycle when `out_ready` is held high.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,…,N-1,0 with no requester skipped. Worst-case wait is N-1 transfers.
- Reset values: `out_valid=0`, `out_data=0`, `sel=0`, `grant=0`, `ptr=0`, `locked=0`, `req_ready=0`.
- Reset mid-transfer: a word pending in the output register is discarded. The first grant after reset goes to the lowest-indexed valid requester.

## Configuration

- `MUX_RR_ARB_LOCK_EN` defined (burst lock):
  - Adds the `req_last` port and a `locked` flag.
  - On a transfer from requester `i` with `req_last[i]=0`: `locked <= 1`, `ptr` is unchanged, and only requester `i` may win until a transfer with `req_last[i]=1`.
  - That last transfer sets `locked <= 0` and `ptr <= i+1`.
  - While locked, if requester `i` drops `req_valid`, no other requester is granted.
- Not defined: every beat is arbitrated independently, `req_last` and `locked` do not exist, and `ptr` advances on every transfer.

## Test plan

- Reset, then a single requester: `req_valid=4'b0100`, `req_data[2]=8'h5A`, `out_ready=1` → next cycle `out_valid=1`, `out_data=8'h5A`, `sel=2`, `grant=4'b0100`.
- All valid, `out_ready=1`, data `8'h10,8'h20,8'h30,8'h40` → `sel` sequence 0,1,2,3,0,1 and one word per cycle.
- Backpressure: output full with `8'h20`, `out_ready=0` for 5 cycles → `out_data` stays `8'h20`, `req_ready=0`. Releasing `out_ready` → the next word appears the following cycle with no loss or duplication.
- Pointer wrap: last grant was 3, then `req_valid=4'b1001` → grant 0, then 3.
- Reset asserted while `out_valid=1` and `ptr=2` → next cycle `out_valid=0`. With `req_valid=4'b1111`, the first grant is 0.
- With `MUX_RR_ARB_LOCK_EN`: requester 1 sends 3 beats, last on beat 3, while requester 2 is valid throughout → `sel` reads 1,1,1,2. Requester 2 is never granted mid-burst.
